// File: rtl/dwc_upconv_rd_cmd_gen.sv
// Read-address front end of the data-width up-converter. Takes one narrow
// master AR, re-issues it as a wide slave AR and pushes one R-path command.
//
// Ports:
//   ACLK, sysReset                 clock, synchronous active-high reset
//   MASTER_AR*                     narrow master AR channel (slave side of us)
//   SLAVE_AR*                      wide slave AR channel (master side of us)
//   cmd_full / cmd_wr_en           command FIFO full flag / one-cycle push
//   cmd_*                          command entry fields for the R up-converter
module dwc_upconv_rd_cmd_gen #(
    parameter int DATA_WIDTH_IN  = 512,
    parameter int DATA_WIDTH_OUT = 32,
    parameter int ID_WIDTH       = 1,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  ACLK,
    input  logic                  sysReset,
    input  logic [ID_WIDTH-1:0]   MASTER_ARID,
    input  logic [ADDR_WIDTH-1:0] MASTER_ARADDR,
    input  logic [7:0]            MASTER_ARLEN,
    input  logic [2:0]            MASTER_ARSIZE,
    input  logic [1:0]            MASTER_ARBURST,
    input  logic                  MASTER_ARVALID,
    output logic                  MASTER_ARREADY,
    output logic [ID_WIDTH-1:0]   SLAVE_ARID,
    output logic [ADDR_WIDTH-1:0] SLAVE_ARADDR,
    output logic [7:0]            SLAVE_ARLEN,
    output logic [2:0]            SLAVE_ARSIZE,
    output logic [1:0]            SLAVE_ARBURST,
    output logic                  SLAVE_ARVALID,
    input  logic                  SLAVE_ARREADY,
    input  logic                  cmd_full,
    output logic                  cmd_wr_en,
    output logic [9:0]            cmd_addr,
    output logic [7:0]            cmd_len,
    output logic                  cmd_len_eq_0,
    output logic [2:0]            cmd_size,
    output logic [ID_WIDTH-1:0]   cmd_id,
    output logic                  cmd_fixed,
    output logic                  cmd_wrap,
    output logic [4:0]            cmd_to_wrap_boundary,
    output logic [9:0]            cmd_mask_pre,
    output logic [9:0]            cmd_rd_src_shift,
    output logic [5:0]            cmd_rd_src_top
);

    localparam int BIN   = DATA_WIDTH_IN / 8;
    localparam int BOUT  = DATA_WIDTH_OUT / 8;
    localparam int LB    = $clog2(BIN);
    localparam int LBOUT = $clog2(BOUT);

    localparam logic [ADDR_WIDTH-1:0] LB_MASK = ADDR_WIDTH'(BIN - 1);
    localparam logic [10:0]           BIN_B   = 11'(BIN);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        ISSUE
    } state_t;

    state_t state_q, state_d;
    logic   ar_done_q, ar_done_d;
    logic   cmd_done_q, cmd_done_d;
    logic   arready_q;
    logic   accept;
    logic   slave_hs;

    logic [ID_WIDTH-1:0]   m_id;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic [7:0]            m_len;
    logic [2:0]            m_size;
    logic [1:0]            m_burst;

    // CALC-stage datapath, all driven from the captured master payload
    logic [12:0]           t_bytes;
    logic [ADDR_WIDTH-1:0] a_aligned;
    logic [13:0]           incr_span;
    logic [7:0]            incr_len;
    logic [7:0]            wrap_len;
    logic [12:0]           wrap_off;
    logic [12:0]           wrap_beats;
    logic                  is_fixed;
    logic                  is_wrap;
    logic                  wrap_big;
    logic [ADDR_WIDTH-1:0] calc_addr;
    logic [7:0]            calc_len;
    logic [1:0]            calc_burst;
    logic [4:0]            calc_twb;
    logic [9:0]            calc_mask;

    assign MASTER_ARREADY = arready_q;
    assign accept   = (state_q == IDLE) && arready_q && MASTER_ARVALID;
    assign SLAVE_ARVALID = (state_q == ISSUE) && !ar_done_q;
    assign slave_hs = SLAVE_ARVALID && SLAVE_ARREADY;
    // Suppressed during reset so a push never races the FIFO reset
    assign cmd_wr_en = (state_q == ISSUE) && !cmd_done_q
                       && !cmd_full && !sysReset;

    assign t_bytes   = ({5'd0, m_len} + 13'd1) << m_size;
    assign a_aligned = (m_addr >> m_size) << m_size;
    // Bytes touched from the wide-beat-aligned base, minus one, in wide beats
    assign incr_span = 14'(a_aligned & LB_MASK) + 14'(t_bytes) - 14'd1;
    assign incr_len  = 8'(incr_span >> LB);
    assign wrap_len  = 8'((t_bytes >> LB) - 13'd1);
    assign wrap_off  = 13'(a_aligned) & (t_bytes - 13'd1);
    assign wrap_beats = (t_bytes - wrap_off) >> m_size;
    assign is_fixed  = (m_burst == BURST_FIXED);
    assign is_wrap   = (m_burst == BURST_WRAP);
    assign wrap_big  = t_bytes > 13'(BIN);
    assign calc_mask = 10'((BIN_B >> m_size) - 11'd1);
    assign calc_twb  = is_wrap ? 5'(wrap_beats - 13'd1) : 5'd0;

    // Reserved burst encoding falls through to the INCR default
    always_comb begin
        calc_addr  = m_addr & ~LB_MASK;
        calc_len   = incr_len;
        calc_burst = BURST_INCR;
        unique case (1'b1)
            is_fixed: begin
                calc_len   = m_len;
                calc_burst = BURST_FIXED;
            end
            is_wrap && wrap_big: begin
                calc_addr  = a_aligned & ~LB_MASK;
                calc_len   = wrap_len;
                calc_burst = BURST_WRAP;
            end
            is_wrap && !wrap_big: begin
                calc_len = 8'd0;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ar_done_d  = ar_done_q;
        cmd_done_d = cmd_done_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = CALC;
            end
            CALC: begin
                ar_done_d  = 1'b0;
                cmd_done_d = 1'b0;
                state_d    = ISSUE;
            end
            ISSUE: begin
                if (slave_hs)  ar_done_d  = 1'b1;
                if (cmd_wr_en) cmd_done_d = 1'b1;
                if (ar_done_d && cmd_done_d) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (sysReset) begin
            state_q    <= IDLE;
            ar_done_q  <= 1'b0;
            cmd_done_q <= 1'b0;
            arready_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ar_done_q  <= ar_done_d;
            cmd_done_q <= cmd_done_d;
            arready_q  <= (state_d == IDLE);
        end
    end

    always_ff @(posedge ACLK) begin
        if (sysReset) begin
            m_id                 <= '0;
            m_addr               <= '0;
            m_len                <= '0;
            m_size               <= '0;
            m_burst              <= '0;
            SLAVE_ARID           <= '0;
            SLAVE_ARADDR         <= '0;
            SLAVE_ARLEN          <= '0;
            SLAVE_ARSIZE         <= '0;
            SLAVE_ARBURST        <= '0;
            cmd_addr             <= '0;
            cmd_len              <= '0;
            cmd_len_eq_0         <= 1'b0;
            cmd_size             <= '0;
            cmd_id               <= '0;
            cmd_fixed            <= 1'b0;
            cmd_wrap             <= 1'b0;
            cmd_to_wrap_boundary <= '0;
            cmd_mask_pre         <= '0;
            cmd_rd_src_shift     <= '0;
            cmd_rd_src_top       <= '0;
        end else begin
            if (accept) begin
                m_id    <= MASTER_ARID;
                m_addr  <= MASTER_ARADDR;
                m_len   <= MASTER_ARLEN;
                m_size  <= MASTER_ARSIZE;
                m_burst <= MASTER_ARBURST;
            end
            if (state_q == CALC) begin
                SLAVE_ARID           <= m_id;
                SLAVE_ARADDR         <= calc_addr;
                SLAVE_ARLEN          <= calc_len;
                SLAVE_ARSIZE         <= 3'(LB);
                SLAVE_ARBURST        <= calc_burst;
                cmd_addr             <= 10'(m_addr[9:0] >> m_size);
                cmd_len              <= m_len;
                cmd_len_eq_0         <= (m_len == 8'd0);
                cmd_size             <= m_size;
                cmd_id               <= m_id;
                cmd_fixed            <= is_fixed;
                cmd_wrap             <= is_wrap;
                cmd_to_wrap_boundary <= calc_twb;
                cmd_mask_pre         <= calc_mask;
                cmd_rd_src_shift     <= 10'(LBOUT) - 10'(m_size);
                cmd_rd_src_top       <= calc_mask[5:0];
            end
        end
    end

endmodule
